// File: rtl/vram_port_arbiter.sv
// -----------------------------------------------------------------------------
// vram_port_arbiter
//
// Shares one single-port board-cell RAM between the pixel renderer and the
// game logic, in the clk_vga domain.
//   - Renderer reads have absolute priority and a fixed latency of
//     1+RAM_LAT cycles from rd_req to rd_valid.
//   - Game-logic writes use valid/ready. They can optionally be held off
//     until vertical blanking so that the visible frame never tears.
//   - A sticky starvation flag and a per-frame write count feed the debug
//     LEDs and the 7-segment display.
//
// RAM_LAT must be 1 or 2 (the RAM read latency after ram_addr).
//
// Ports
//   clk_vga            pixel clock
//   reset_n            asynchronous reset, active-low
//   vblank             high during vertical blanking
//   frame_start        one-cycle pulse at the first cycle of each frame
//   rd_req/rd_addr     renderer read request and address
//   rd_data/rd_valid   read data; it holds its value between rd_valid pulses
//   wr_valid/wr_addr/wr_data/wr_ready
//                      game-logic write handshake; wr_ready is combinational
//   ram_addr/ram_we/ram_wdata
//                      registered RAM port
//   ram_rdata          RAM read data, RAM_LAT cycles after ram_addr
//   starve_flag        sticky write-starvation flag, cleared by frame_start
//   last_frame_writes  writes accepted during the previous frame
// -----------------------------------------------------------------------------
module vram_port_arbiter #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 16,
  parameter int RAM_LAT       = 1,
  parameter int STARVE_LIMIT  = 64,
  parameter bit WR_BLANK_ONLY = 1'b1
) (
  input  logic              clk_vga,
  input  logic              reset_n,
  input  logic              vblank,
  input  logic              frame_start,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              starve_flag,
  output logic [15:0]       last_frame_writes
);

  localparam int VLD_DEPTH = 1 + RAM_LAT;

  localparam logic [1:0] GNT_IDLE = 2'd0;
  localparam logic [1:0] GNT_RD   = 2'd1;
  localparam logic [1:0] GNT_WR   = 2'd2;

  localparam logic [7:0]  STALL_MAX   = 8'hFF;
  localparam logic [7:0]  STARVE_LIM8 = 8'(STARVE_LIMIT);
  localparam logic [15:0] WR_CNT_MAX  = 16'hFFFF;

  // ---------------------------------------------------------------------------
  // Grant
  // ---------------------------------------------------------------------------
  logic [1:0] grant;
  logic       wr_window;
  logic       wr_acc;
  logic       wr_stall;

  assign wr_window = (WR_BLANK_ONLY == 1'b0) || vblank;

  // The grant is gated by reset_n so that wr_ready stays low while the block
  // is held in reset, even if a writer is already presenting a request.
  always_comb begin
    grant = GNT_IDLE;
    if (!reset_n) begin
      grant = GNT_IDLE;
    end else if (rd_req) begin
      grant = GNT_RD;
    end else if (wr_valid && wr_window) begin
      grant = GNT_WR;
    end
  end

  assign wr_ready = (grant == GNT_WR);
  assign wr_acc   = wr_valid && wr_ready;
  assign wr_stall = wr_valid && !wr_ready;

  // ---------------------------------------------------------------------------
  // Registered RAM port. ram_wdata changes only on a write, which keeps the
  // data bus quiet during read bursts.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
    end else begin
      case (grant)
        GNT_RD: begin
          ram_addr <= rd_addr;
          ram_we   <= 1'b0;
        end
        GNT_WR: begin
          ram_addr  <= wr_addr;
          ram_wdata <= wr_data;
          ram_we    <= 1'b1;
        end
        default: begin
          ram_we <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read return path
  // Stage 0 covers the cycle in which ram_addr is presented. The last stage
  // lines up with ram_rdata, so every issued read returns exactly once, in
  // issue order, and back-to-back reads give back-to-back rd_valid pulses.
  // ---------------------------------------------------------------------------
  logic [VLD_DEPTH-1:0] vld_sr;
  logic [DATA_W-1:0]    rd_hold;

  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      vld_sr <= '0;
    end else begin
      vld_sr <= {vld_sr[VLD_DEPTH-2:0], grant == GNT_RD};
    end
  end

  assign rd_valid = vld_sr[VLD_DEPTH-1];

  // RAM data passes straight through in the valid cycle. rd_hold keeps that
  // value so rd_data stays stable until the next return.
  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      rd_hold <= '0;
    end else if (rd_valid) begin
      rd_hold <= ram_rdata;
    end
  end

  assign rd_data = rd_valid ? ram_rdata : rd_hold;

  // ---------------------------------------------------------------------------
  // Write starvation
  // The flag is set only on the cycle in which the stall count reaches the
  // limit. A frame_start during a long ongoing stall therefore clears the
  // flag, and the flag is not set again until a new stall run reaches the
  // limit.
  // ---------------------------------------------------------------------------
  logic [7:0] stall_cnt;
  logic [7:0] stall_nxt;
  logic       starve_set;

  always_comb begin
    stall_nxt = 8'd0;
    if (wr_stall) begin
      stall_nxt = (stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + 8'd1;
    end
  end

  assign starve_set = wr_stall && (stall_cnt != STARVE_LIM8) &&
                      (stall_nxt == STARVE_LIM8);

  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt   <= 8'd0;
      starve_flag <= 1'b0;
    end else begin
      stall_cnt <= stall_nxt;
      if (starve_set) begin
        starve_flag <= 1'b1;
      end else if (frame_start) begin
        starve_flag <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-frame write counter. A write accepted in the frame_start cycle still
  // belongs to the frame that is ending.
  // ---------------------------------------------------------------------------
  logic [15:0] wr_cnt;
  logic [15:0] wr_cnt_inc;

  always_comb begin
    wr_cnt_inc = wr_cnt;
    if (wr_acc && (wr_cnt != WR_CNT_MAX)) begin
      wr_cnt_inc = wr_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt            <= 16'd0;
      last_frame_writes <= 16'd0;
    end else if (frame_start) begin
      last_frame_writes <= wr_cnt_inc;
      wr_cnt            <= 16'd0;
    end else begin
      wr_cnt <= wr_cnt_inc;
    end
  end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_port_arbiter
//
// Self-checking bench for vram_port_arbiter.
//   - A behavioural RAM is attached to the DUT's RAM port.
//   - A transaction-level reference model runs every cycle. It keeps a queue
//     of expected read returns, a shadow memory, a stall-run length and a
//     per-frame write count.
//   - The bench also applies a directed vector table and a few hand-written
//     corner sequences, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_vram_port_arbiter;

  localparam int ADDR_W        = 8;
  localparam int DATA_W        = 16;
  localparam int RAM_LAT       = 1;
  localparam int STARVE_LIMIT  = 64;
  localparam bit WR_BLANK_ONLY = 1'b1;

  logic              clk_vga     = 1'b0;
  logic              reset_n     = 1'b1;
  logic              vblank      = 1'b0;
  logic              frame_start = 1'b0;
  logic              rd_req      = 1'b0;
  logic [ADDR_W-1:0] rd_addr     = '0;
  logic              wr_valid    = 1'b0;
  logic [ADDR_W-1:0] wr_addr     = '0;
  logic [DATA_W-1:0] wr_data     = '0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              starve_flag;
  logic [15:0]       last_frame_writes;

  vram_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .RAM_LAT      (RAM_LAT),
    .STARVE_LIMIT (STARVE_LIMIT),
    .WR_BLANK_ONLY(WR_BLANK_ONLY)
  ) dut (
    .clk_vga          (clk_vga),
    .reset_n          (reset_n),
    .vblank           (vblank),
    .frame_start      (frame_start),
    .rd_req           (rd_req),
    .rd_addr          (rd_addr),
    .rd_data          (rd_data),
    .rd_valid         (rd_valid),
    .wr_valid         (wr_valid),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .wr_ready         (wr_ready),
    .ram_addr         (ram_addr),
    .ram_we           (ram_we),
    .ram_wdata        (ram_wdata),
    .ram_rdata        (ram_rdata),
    .starve_flag      (starve_flag),
    .last_frame_writes(last_frame_writes)
  );

  always #5 clk_vga = ~clk_vga;

  // Behavioural cell RAM. Every cell initially holds addr ^ 0xA5A5.
  logic [DATA_W-1:0] mem   [256];
  logic [DATA_W-1:0] rpipe [RAM_LAT];
  bit                ram_init_done = 1'b0;

  always @(posedge clk_vga) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'(i) ^ 16'hA5A5;
      ram_init_done <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    rpipe[0] <= mem[ram_addr];
    for (int k = 1; k < RAM_LAT; k++) rpipe[k] <= rpipe[k-1];
  end

  assign ram_rdata = rpipe[RAM_LAT-1];

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    int          due;
    logic [15:0] data;
  } rd_resp_t;

  rd_resp_t    rq[$];
  logic [15:0] ref_mem [256];
  int          cyc = 0;
  logic [7:0]  m_ram_addr;
  logic        m_ram_we;
  logic [15:0] m_ram_wdata;
  logic        m_rd_valid;
  logic [15:0] m_rd_data;
  int          m_stall;
  logic        m_starve;
  int          m_wr_cnt;
  int          m_last;
  logic        m_acc;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    rq.delete();
    m_ram_addr  = '0;
    m_ram_we    = 1'b0;
    m_ram_wdata = '0;
    m_rd_valid  = 1'b0;
    m_rd_data   = '0;
    m_stall     = 0;
    m_starve    = 1'b0;
    m_wr_cnt    = 0;
    m_last      = 0;
    m_acc       = 1'b0;
  endtask

  task automatic check_model();
    chk("ram_we",            32'(ram_we),            32'(m_ram_we));
    chk("ram_addr",          32'(ram_addr),          32'(m_ram_addr));
    chk("ram_wdata",         32'(ram_wdata),         32'(m_ram_wdata));
    chk("rd_valid",          32'(rd_valid),          32'(m_rd_valid));
    chk("rd_data",           32'(rd_data),           32'(m_rd_data));
    chk("starve_flag",       32'(starve_flag),       32'(m_starve));
    chk("last_frame_writes", 32'(last_frame_writes), 32'(m_last));
  endtask

  // Apply the current inputs for one cycle. wr_ready is checked before the
  // clock edge; the registered outputs are checked just after it.
  task automatic tick();
    rd_resp_t r;
    #1;
    m_acc = reset_n && !rd_req && wr_valid && (!WR_BLANK_ONLY || vblank);
    chk("wr_ready", 32'(wr_ready), 32'(m_acc));
    if (!reset_n) begin
      model_clear();
    end else begin
      if (rd_req) begin
        r.due  = cyc + 1 + RAM_LAT;
        r.data = ref_mem[rd_addr];
        rq.push_back(r);
        m_ram_addr = rd_addr;
        m_ram_we   = 1'b0;
      end else if (m_acc) begin
        ref_mem[wr_addr] = wr_data;
        m_ram_addr  = wr_addr;
        m_ram_wdata = wr_data;
        m_ram_we    = 1'b1;
      end else begin
        m_ram_we = 1'b0;
      end
      if (wr_valid && !m_acc) m_stall++;
      else m_stall = 0;
      if (m_stall == STARVE_LIMIT) m_starve = 1'b1;
      else if (frame_start) m_starve = 1'b0;
      if (m_acc && m_wr_cnt < 65535) m_wr_cnt++;
      if (frame_start) begin
        m_last   = m_wr_cnt;
        m_wr_cnt = 0;
      end
    end
    @(posedge clk_vga);
    cyc++;
    #1;
    m_rd_valid = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      m_rd_valid = 1'b1;
      m_rd_data  = rq[0].data;
      void'(rq.pop_front());
    end
    check_model();
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        rd_req;
    logic [7:0]  rd_addr;
    logic        wr_valid;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        vblank;
    logic        e_wr_ready;
    logic        e_ram_we;
    logic [7:0]  e_ram_addr;
    logic        e_rd_valid;
    logic [15:0] e_rd_data;
  } vec_t;

  vec_t vt[16];

  initial begin
    // Read latency: three back-to-back reads.
    vt[0]  = '{1'b1, 8'h10, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 16'h0000};
    vt[1]  = '{1'b1, 8'h11, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 16'hA5B5};
    vt[2]  = '{1'b1, 8'h12, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h12, 1'b1, 16'hA5B4};
    vt[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h12, 1'b1, 16'hA5B7};
    vt[4]  = '{1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h12, 1'b0, 16'hA5B7};
    // Blank gating: the write waits for vblank, then a read issued in the
    // very next cycle sees the new data.
    vt[5]  = '{1'b0, 8'h00, 1'b1, 8'h20, 16'h1234, 1'b0, 1'b0, 1'b0, 8'h12, 1'b0, 16'hA5B7};
    vt[6]  = '{1'b0, 8'h00, 1'b1, 8'h20, 16'h1234, 1'b0, 1'b0, 1'b0, 8'h12, 1'b0, 16'hA5B7};
    vt[7]  = '{1'b0, 8'h00, 1'b1, 8'h20, 16'h1234, 1'b1, 1'b1, 1'b1, 8'h20, 1'b0, 16'hA5B7};
    vt[8]  = '{1'b1, 8'h20, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h20, 1'b0, 16'hA5B7};
    vt[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h20, 1'b1, 16'h1234};
    vt[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 16'h1234};
    // Collision: reads preempt a pending write for three cycles.
    vt[11] = '{1'b1, 8'h01, 1'b1, 8'h30, 16'hBEEF, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 16'h1234};
    vt[12] = '{1'b1, 8'h02, 1'b1, 8'h30, 16'hBEEF, 1'b1, 1'b0, 1'b0, 8'h02, 1'b1, 16'hA5A4};
    vt[13] = '{1'b1, 8'h03, 1'b1, 8'h30, 16'hBEEF, 1'b1, 1'b0, 1'b0, 8'h03, 1'b1, 16'hA5A7};
    vt[14] = '{1'b0, 8'h00, 1'b1, 8'h30, 16'hBEEF, 1'b1, 1'b1, 1'b1, 8'h30, 1'b1, 16'hA5A6};
    vt[15] = '{1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h30, 1'b0, 16'hA5A6};
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'(i) ^ 16'hA5A5;
    model_clear();

    // Reset asserted while both requesters are active.
    #1;
    reset_n  = 1'b0;
    rd_req   = 1'b1;
    wr_valid = 1'b1;
    vblank   = 1'b1;
    #1;
    chk("rst rd_data",   32'(rd_data),           32'h0);
    chk("rst rd_valid",  32'(rd_valid),          32'h0);
    chk("rst wr_ready",  32'(wr_ready),          32'h0);
    chk("rst ram_addr",  32'(ram_addr),          32'h0);
    chk("rst ram_we",    32'(ram_we),            32'h0);
    chk("rst ram_wdata", 32'(ram_wdata),         32'h0);
    chk("rst starve",    32'(starve_flag),       32'h0);
    chk("rst last_fw",   32'(last_frame_writes), 32'h0);
    tick();
    tick();
    rd_req   = 1'b0;
    wr_valid = 1'b0;
    vblank   = 1'b0;
    reset_n  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle ram_we",   32'(ram_we),   32'h0);
      chk("idle rd_valid", 32'(rd_valid), 32'h0);
    end

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      rd_req   = vt[i].rd_req;
      rd_addr  = vt[i].rd_addr;
      wr_valid = vt[i].wr_valid;
      wr_addr  = vt[i].wr_addr;
      wr_data  = vt[i].wr_data;
      vblank   = vt[i].vblank;
      #1;
      chk($sformatf("vec%0d wr_ready", i), 32'(wr_ready), 32'(vt[i].e_wr_ready));
      tick();
      chk($sformatf("vec%0d ram_we", i),   32'(ram_we),   32'(vt[i].e_ram_we));
      chk($sformatf("vec%0d ram_addr", i), 32'(ram_addr), 32'(vt[i].e_ram_addr));
      chk($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(vt[i].e_rd_valid));
      chk($sformatf("vec%0d rd_data", i),  32'(rd_data),  32'(vt[i].e_rd_data));
    end

    // Starvation: a write held outside blanking sets the flag after 64 stalls.
    vblank   = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = 8'h40;
    wr_data  = 16'h5555;
    for (int i = 1; i <= 70; i++) begin
      tick();
      chk($sformatf("starve run %0d", i), 32'(starve_flag), (i >= 64) ? 32'h1 : 32'h0);
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("starve cleared", 32'(starve_flag), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("starve stays clear", 32'(starve_flag), 32'h0);
    end
    wr_valid = 1'b0;
    tick();
    // Limit reached in the same cycle as frame_start: the set wins.
    wr_valid = 1'b1;
    for (int i = 1; i <= 63; i++) tick();
    chk("starve at 63", 32'(starve_flag), 32'h0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("starve set wins", 32'(starve_flag), 32'h1);
    wr_valid = 1'b0;
    tick();
    chk("starve sticky", 32'(starve_flag), 32'h1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("starve frame clear", 32'(starve_flag), 32'h0);

    // Frame write count.
    vblank = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_addr  = 8'(8'h50 + i);
      wr_data  = 16'(16'h0100 + i);
      tick();
    end
    wr_valid    = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("frame writes 5", 32'(last_frame_writes), 32'd5);
    for (int i = 0; i < 6; i++) begin
      wr_valid    = 1'b1;
      wr_addr     = 8'(8'h60 + i);
      wr_data     = 16'(16'h0200 + i);
      frame_start = (i == 5);
      tick();
    end
    wr_valid    = 1'b0;
    frame_start = 1'b0;
    chk("frame writes 6", 32'(last_frame_writes), 32'd6);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("frame writes 0", 32'(last_frame_writes), 32'd0);

    // Reset in the middle of a read: the in-flight read never returns.
    vblank  = 1'b0;
    rd_req  = 1'b1;
    rd_addr = 8'h05;
    tick();
    rd_req  = 1'b0;
    reset_n = 1'b0;
    #1;
    model_clear();
    check_model();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post-rst rd_valid", 32'(rd_valid), 32'h0);
      chk("post-rst ram_we",   32'(ram_we),   32'h0);
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 2000; i++) begin
      rd_req  = ($urandom_range(0, 99) < 30);
      rd_addr = 8'($urandom_range(0, 31));
      if (!(wr_valid && !m_acc)) begin
        wr_valid = ($urandom_range(0, 99) < 50);
        wr_addr  = 8'($urandom_range(0, 31));
        wr_data  = 16'($urandom);
      end
      if ($urandom_range(0, 99) < 4) vblank = ~vblank;
      frame_start = ($urandom_range(0, 99) < 2);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Shares one single-port board-cell RAM between two requesters: the pixel renderer (reads, fixed latency, absolute priority) and game logic (writes, valid/ready).
- Sits in the clk_vga domain between the renderer feeding Pixel_Controller gen_* inputs and the cell RAM.
- Can hold writes to vertical blanking to prevent tearing.
- Reports write starvation and per-frame write counts for debug LEDs and the 7-segment display.

Parameters:
ADDR_W, 8, cell RAM address width (16x16 board)
DATA_W, 16, cell word width (owner, army count)
RAM_LAT, 1, RAM read latency in cycles; legal values are 1 and 2
STARVE_LIMIT, 64, consecutive stalled-write cycles before starve_flag is set
WR_BLANK_ONLY, 1, 1 = writes granted only while vblank=1

Ports:
clk_vga  in  1  pixel clock (50 MHz)
reset_n  in  1  asynchronous reset, active-low
vblank  in  1  level, high during vertical blanking
frame_start  in  1  one-cycle pulse at first cycle of each frame
rd_req  in  1  renderer read request
rd_addr  in  ADDR_W  renderer read address
rd_data  out  DATA_W  read data
rd_valid  out  1  rd_data valid
wr_valid  in  1  game-logic write request
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_ready  out  1  write accepted this cycle (combinational)
ram_addr  out  ADDR_W  RAM address (registered)
ram_we  out  1  RAM write enable (registered)
ram_wdata  out  DATA_W  RAM write data (registered)
ram_rdata  in  DATA_W  RAM read data, valid RAM_LAT cycles after ram_addr
starve_flag  out  1  sticky starvation indicator
last_frame_writes  out  16  writes accepted in previous frame

Behaviour:
- Reset: all outputs 0, counters 0, read pipeline cleared. Asserting reset_n=0 mid-read discards in-flight reads; no rd_valid follows reset release for them.
- Grant each cycle (combinational):
  - rd_req=1 -> GNT_RD.
  - Otherwise wr_valid=1 and (WR_BLANK_ONLY=0 or vblank=1) -> GNT_WR.
  - Otherwise IDLE.
  - wr_ready = (grant==GNT_WR). A write is accepted when wr_valid && wr_ready.
  - wr_ready may be high only while wr_valid=1. Writer must hold wr_addr/wr_data stable until accepted.
- Port register, cycle t+1:
  - GNT_RD: ram_addr=rd_addr, ram_we=0.
  - GNT_WR: ram_addr=wr_addr, ram_wdata=wr_data, ram_we=1.
  - IDLE: ram_we=0; ram_addr and ram_wdata hold.
- Read latency:
  - rd_valid pulses exactly 1+RAM_LAT cycles after the rd_req cycle; rd_data=ram_rdata in that cycle, then holds until the next rd_valid.
  - Back-to-back reads give back-to-back rd_valid, one read per cycle.
  - Implement as a valid shift register of depth 1+RAM_LAT.
- Ordering: a write accepted at cycle t is visible to a read requested at cycle ≥ t+1. The port is single-issue, so no same-cycle hazard exists.
- Starvation:
  - stall_cnt (8 bit, saturating) increments each cycle wr_valid=1 && !wr_ready; resets to 0 on acceptance or when wr_valid=0.
  - When stall_cnt reaches STARVE_LIMIT, starve_flag<=1. starve_flag stays sticky until frame_start.
  - If frame_start and the limit-reach occur in the same cycle, the set wins.
- Frame counter:
  - wr_cnt (16 bit) increments on each accepted write and saturates at 0xFFFF.
  - On frame_start: last_frame_writes<=wr_cnt (+1 if a write is accepted that same cycle, saturated); wr_cnt<=0.
- No rd_req during blanking is expected. If one arrives, it is served normally and still preempts writes.

Test Plan:
- Reset: reset_n=0 with rd_req=1, wr_valid=1 -> all outputs 0. Release with no requests -> ram_we=0, rd_valid=0 for 10 cycles.
- Read latency, RAM_LAT=1: rd_req at cycles 5,6,7, addrs 0x10,0x11,0x12, RAM model data=addr^0xA5A5 -> rd_valid at cycles 7,8,9 with data 0xA5B5,0xA5B4,0xA5B7.
- Blank gating, WR_BLANK_ONLY=1: wr_valid addr 0x20 data 0x1234 at vblank=0 -> wr_ready=0. vblank rises at cycle 30 -> wr_ready=1 at 30, ram_we=1 with ram_addr=0x20 at 31. A read of 0x20 at 32 returns 0x1234.
- Collision: vblank=1, rd_req and wr_valid both high for 3 cycles -> 3 reads issued with wr_ready=0. Write accepted on the 4th cycle after rd_req drops.
- Starvation: wr_valid held with vblank=0 for 70 cycles -> starve_flag=1 at stall 64 and stays 1. The next frame_start clears it.
- Frame count: 5 writes accepted during vblank, then frame_start -> last_frame_writes=5, wr_cnt=0. A write accepted in the same cycle as frame_start is counted in that frame (6).
